// File: rtl/booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mult_arbiter
//
// Shares one sequential booth_mult instance (en/done handshake) between NREQ
// independent requesters. A round-robin arbiter picks the next requester,
// captures its operands, drives the multiplier until done and returns the
// product tagged with the requester index.
//
// Optional feature (compile-time macro): BOOTH_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts a multiply that has not produced done
//   within TIMEOUT BUSY cycles and returns res_err=1, res_M=0.
//   When undefined, there is no watchdog and res_err is tied to 0.
//
// Handshake semantics (requester side):
//   A requester raises req_valid[i] with stable req_A/req_B slices and holds
//   them until grant[i] pulses; grant[i] means the operands were captured on
//   that edge. Dropping req_valid before grant withdraws the request. A level
//   still high after grant is a fresh request. Results carry no backpressure:
//   res_valid is a one-cycle pulse the consumer must take.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]        per-requester request level
//   req_A      in   [NREQ*width]  operand A, slice i = [i*width +: width]
//   req_B      in   [NREQ*width]  operand B, same slicing
//   grant      out  [NREQ]        one-hot pulse, operands captured
//   res_valid  out                one-cycle result pulse
//   res_id     out  [IDW]         owner of the result
//   res_M      out  [2*width]     signed product
//   res_err    out                result aborted by watchdog
//   busy       out                state != IDLE
//   mult_en    out                multiplier en
//   mult_A     out  [width]       multiplier A
//   mult_B     out  [width]       multiplier B
//   mult_done  in                 multiplier done
//   mult_M     in   [2*width]     multiplier product
//   dbg_state  out  [2]           current FSM state (0 IDLE, 1 BUSY, 2 RELEASE)
// ---------------------------------------------------------------------------
module booth_mult_arbiter #(
    parameter int width   = 8,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*width-1:0]   req_A,
    input  logic [NREQ*width-1:0]   req_B,
    output logic [NREQ-1:0]         grant,
    output logic                    res_valid,
    output logic [IDW-1:0]          res_id,
    output logic [2*width-1:0]      res_M,
    output logic                    res_err,
    output logic                    busy,
    output logic                    mult_en,
    output logic [width-1:0]        mult_A,
    output logic [width-1:0]        mult_B,
    input  logic                    mult_done,
    input  logic [2*width-1:0]      mult_M,
    output logic [1:0]              dbg_state
);

    if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT < 1) begin : g_bad_param
        $error("booth_mult_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [NREQ-1:0]      r_grant,     w_grant_nxt;
    logic                 r_res_valid, w_res_valid_nxt;
    logic [IDW-1:0]       r_res_id,    w_res_id_nxt;
    logic [2*width-1:0]   r_res_M,     w_res_M_nxt;
    logic                 r_mult_en,   w_mult_en_nxt;
    logic [width-1:0]     r_mult_A,    w_mult_A_nxt;
    logic [width-1:0]     r_mult_B,    w_mult_B_nxt;
    logic [IDW-1:0]       r_rr_ptr,    w_rr_nxt;
    logic [IDW-1:0]       r_cur_id,    w_cur_id_nxt;
    logic                 r_busy;

    logic [IDW-1:0]       w_winner;
    logic                 w_found;
    int                   w_idx;
    logic                 w_timeout;

    // Round-robin search: first set request bit at or above rr_ptr, wrapping.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found) begin
                w_idx = int'(r_rr_ptr) + k;
                if (w_idx >= NREQ) begin
                    w_idx = w_idx - NREQ;
                end
                if (req_valid[w_idx]) begin
                    w_found  = 1'b1;
                    w_winner = IDW'(w_idx);
                end
            end
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] r_wdog, w_wdog_nxt;
    logic           r_res_err, w_res_err_nxt;

    // Fires on the TIMEOUT-th BUSY edge; done on the same edge takes priority
    // in the main next-state logic.
    assign w_timeout = (r_state == S_BUSY) && (r_wdog == WDW'(TIMEOUT - 1));

    always_comb begin
        w_wdog_nxt    = r_wdog;
        w_res_err_nxt = r_res_err;
        case (r_state)
            S_IDLE: w_wdog_nxt = '0;
            S_BUSY: begin
                w_wdog_nxt = r_wdog + WDW'(1);
                if (mult_done) begin
                    w_res_err_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_res_err_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog    <= '0;
            r_res_err <= 1'b0;
        end else begin
            r_wdog    <= w_wdog_nxt;
            r_res_err <= w_res_err_nxt;
        end
    end

    assign res_err = r_res_err;
`else
    assign w_timeout = 1'b0;
    assign res_err   = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = '0;
        w_res_valid_nxt = 1'b0;
        w_res_id_nxt    = r_res_id;
        w_res_M_nxt     = r_res_M;
        w_mult_en_nxt   = r_mult_en;
        w_mult_A_nxt    = r_mult_A;
        w_mult_B_nxt    = r_mult_B;
        w_rr_nxt        = r_rr_ptr;
        w_cur_id_nxt    = r_cur_id;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt[w_winner] = 1'b1;
                    w_mult_A_nxt  = req_A[w_winner*width +: width];
                    w_mult_B_nxt  = req_B[w_winner*width +: width];
                    w_mult_en_nxt = 1'b1;
                    w_cur_id_nxt  = w_winner;
                    w_rr_nxt      = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + IDW'(1);
                    w_state_nxt   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mult_done) begin
                    w_res_valid_nxt = 1'b1;
                    w_res_M_nxt     = mult_M;
                    w_res_id_nxt    = r_cur_id;
                    w_mult_en_nxt   = 1'b0;
                    w_state_nxt     = S_RELEASE;
                end else if (w_timeout) begin
                    w_res_valid_nxt = 1'b1;
                    w_res_M_nxt     = '0;
                    w_res_id_nxt    = r_cur_id;
                    w_mult_en_nxt   = 1'b0;
                    w_state_nxt     = S_RELEASE;
                end
            end
            // One cycle with en low lets the multiplier drop done; a done
            // still visible here is stale and ignored.
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mult_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_M     <= '0;
            r_mult_en   <= 1'b0;
            r_mult_A    <= '0;
            r_mult_B    <= '0;
            r_rr_ptr    <= '0;
            r_cur_id    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_id    <= w_res_id_nxt;
            r_res_M     <= w_res_M_nxt;
            r_mult_en   <= w_mult_en_nxt;
            r_mult_A    <= w_mult_A_nxt;
            r_mult_B    <= w_mult_B_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_cur_id    <= w_cur_id_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign grant     = r_grant;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_M     = r_res_M;
    assign busy      = r_busy;
    assign mult_en   = r_mult_en;
    assign mult_A    = r_mult_A;
    assign mult_B    = r_mult_B;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_arbiter
//
// Directed bench for booth_mult_arbiter with a behavioural multiplier model
// (fixed latency, optional stall so done never rises). Expected grants and
// tagged results are pushed into queues when stimulus is issued; a separate
// monitor pops and compares whenever grant or res_valid is presented.
// ---------------------------------------------------------------------------
module tb_booth_mult_arbiter;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 8;
    localparam int W       = 1 + IDW + 2*WIDTH;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*WIDTH-1:0]  req_A;
    logic [NREQ*WIDTH-1:0]  req_B;
    logic [NREQ-1:0]        grant;
    logic                   res_valid;
    logic [IDW-1:0]         res_id;
    logic [2*WIDTH-1:0]     res_M;
    logic                   res_err;
    logic                   busy;
    logic                   mult_en;
    logic [WIDTH-1:0]       mult_A;
    logic [WIDTH-1:0]       mult_B;
    logic                   mult_done;
    logic [2*WIDTH-1:0]     mult_M;
    logic [1:0]             dbg_state;

    booth_mult_arbiter #(
        .width   (WIDTH),
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_A     (req_A),
        .req_B     (req_B),
        .grant     (grant),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_M     (res_M),
        .res_err   (res_err),
        .busy      (busy),
        .mult_en   (mult_en),
        .mult_A    (mult_A),
        .mult_B    (mult_B),
        .mult_done (mult_done),
        .mult_M    (mult_M),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected to finish");
        $fatal(1, "global timeout");
    end

    // ---------------- multiplier model ----------------
    logic                     m_stall;
    logic [2:0]               m_cnt;
    logic signed [2*WIDTH-1:0] m_a;
    logic signed [2*WIDTH-1:0] m_b;
    logic signed [2*WIDTH-1:0] m_prod;

    assign m_a    = {{WIDTH{mult_A[WIDTH-1]}}, mult_A};
    assign m_b    = {{WIDTH{mult_B[WIDTH-1]}}, mult_B};
    assign m_prod = m_a * m_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_done <= 1'b0;
            mult_M    <= '0;
            m_cnt     <= '0;
        end else if (!mult_en) begin
            mult_done <= 1'b0;
            m_cnt     <= '0;
        end else if (!mult_done) begin
            if (m_cnt == 3'd3 && !m_stall) begin
                mult_done <= 1'b1;
                mult_M    <= m_prod;
            end else begin
                m_cnt <= m_cnt + 3'd1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0]   exp_q[$];
    logic [IDW-1:0] exp_g_q[$];
    int checks   = 0;
    int failures = 0;
    int n_grants = 0;
    int since_res = 1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no/unexpected event, required the expected event", name);
    endtask

    task automatic exp_push(input int id, input logic [2*WIDTH-1:0] m, input logic err);
        exp_g_q.push_back(IDW'(id));
        exp_q.push_back({err, IDW'(id), m});
    endtask

    // Monitor: compares every grant and result against the queues.
    initial begin
        logic [W-1:0]    e;
        logic [IDW-1:0]  g;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                since_res = 1000;
            end else begin
                since_res++;
                if (grant != '0) begin
                    n_grants++;
                    chk("grant_onehot", $countones(grant), 1);
                    chk("grant_gap_ge2", (since_res >= 2) ? 32'd1 : 32'd0, 1);
                    chk("busy_at_grant", busy, 1);
                    chk("en_at_grant", mult_en, 1);
                    if (exp_g_q.size() == 0) begin
                        fail_now("grant_unexpected");
                    end else begin
                        g  = exp_g_q.pop_front();
                        oh = '0;
                        oh[g] = 1'b1;
                        chk("grant_vec", grant, oh);
                    end
                end
                if (res_valid) begin
                    chk("en_low_at_result", mult_en, 0);
                    if (exp_q.size() == 0) begin
                        fail_now("result_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_err_id_M", {res_err, res_id, res_M}, e);
                    end
                    since_res = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int id, input int a, input int b);
        req_A[id*WIDTH +: WIDTH] = WIDTH'(a);
        req_B[id*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_res"}, {res_valid, res_id, res_M, res_err}, 0);
        chk({tag, "_mult"}, {mult_en, mult_A, mult_B}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // Waits for grant[id], then withdraws the level so it is not re-requested.
    task automatic wait_grant(input int id);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (grant[id]) seen = 1'b1;
        end
        if (!seen) fail_now("grant_wait_timeout");
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_drain();
        bit done_q;
        done_q = 1'b0;
        for (int n = 0; n < 300 && !done_q; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_g_q.size() == 0) done_q = 1'b1;
        end
        if (!done_q) fail_now("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs(tag);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic single(input int id, input int a, input int b, input logic [2*WIDTH-1:0] m);
        set_req(id, a, b);
        exp_push(id, m, 1'b0);
        req_valid[id] = 1'b1;
        wait_grant(id);
        wait_drain();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int target;
        rst_n     = 1'b0;
        req_valid = '0;
        req_A     = '0;
        req_B     = '0;
        m_stall   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester: 3 * -4 = -12
        single(0, 3, -4, 16'hFFF4);

        // Two simultaneous requests from rr_ptr=0: 0 first, then 2
        do_reset("rst_a");
        set_req(0, 5, 6);
        set_req(2, -7, 2);
        exp_push(0, 16'd30, 1'b0);
        exp_push(2, 16'hFFF2, 1'b0);
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        wait_grant(0);
        wait_grant(2);
        wait_drain();

        // All four held: order 0,1,2,3,0
        do_reset("rst_b");
        set_req(0, 2, 3);
        set_req(1, -1, 5);
        set_req(2, 10, -10);
        set_req(3, -3, -3);
        exp_push(0, 16'd6, 1'b0);
        exp_push(1, 16'hFFFB, 1'b0);
        exp_push(2, 16'hFF9C, 1'b0);
        exp_push(3, 16'd9, 1'b0);
        exp_push(0, 16'd6, 1'b0);
        target = n_grants + 5;
        req_valid = 4'hF;
        for (int n = 0; n < 300 && n_grants < target; n++) @(negedge clk);
        chk("rr_grant_count", n_grants, target);
        req_valid = '0;
        wait_drain();

        // Operand extremes
        single(1, -128, -128, 16'h4000);
        single(2, 127, -128, 16'hC080);
        single(3, 0, -1, 16'h0000);

        // Reset while BUSY: no result, rr_ptr back to 0
        set_req(1, 4, 4);
        exp_g_q.push_back(IDW'(1));
        req_valid[1] = 1'b1;
        wait_grant(1);
        repeat (2) @(negedge clk);
        chk("midop_busy_before_rst", {busy, mult_en}, 2'b11);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midop");
        set_req(3, -2, 9);
        exp_push(1, 16'd16, 1'b0);
        exp_push(3, 16'hFFEE, 1'b0);
        req_valid = 4'b1010;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_grant(1);
        wait_grant(3);
        wait_drain();

`ifdef BOOTH_ARB_TIMEOUT_EN
        // Watchdog: done never arrives, abort on 8th BUSY cycle
        begin
            int k;
            bit got;
            m_stall = 1'b1;
            set_req(0, 1, 1);
            exp_push(0, 16'h0000, 1'b1);
            req_valid[0] = 1'b1;
            wait_grant(0);
            k   = 0;
            got = 1'b0;
            for (int n = 0; n < 40 && !got; n++) begin
                @(negedge clk);
                k++;
                if (res_valid) got = 1'b1;
            end
            chk("timeout_latency", k, TIMEOUT);
            m_stall = 1'b0;
            wait_drain();
            single(2, 3, 3, 16'd9);
        end
`endif

        // ---------------- final report ----------------
        chk("exp_q_empty", exp_q.size(), 0);
        chk("grant_q_empty", exp_g_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
